// File: rtl/cfg_link_pkg.sv
// Shared constants and FSM encoding for the 3-wire configuration link receiver.
package cfg_link_pkg;
  localparam int                   CFG_WIDTH = 33;
  localparam logic [CFG_WIDTH-1:0] RESET_CFG = 33'h03CF10404;
  localparam int                   CNT_W     = $clog2(CFG_WIDTH + 2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;
endpackage

// File: rtl/config_shift_receiver_sync_ff.sv
// Async-reset multi-flop bit synchronizer for pins crossing into clk.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= '0;
    else        ff_q <= {ff_q[STAGES-2:0], d_i};
  end

  assign q_o = ff_q[STAGES-1];
endmodule

// File: rtl/config_shift_receiver.sv
// Serial configuration receiver: synchronizes en/sclk/data, shifts LSB-first and
// commits the word to cfg_out only when exactly CFG_WIDTH bits arrived.
module config_shift_receiver #(
  parameter int                   CFG_WIDTH   = cfg_link_pkg::CFG_WIDTH,
  parameter int                   SYNC_STAGES = 2,
  parameter logic [CFG_WIDTH-1:0] RESET_CFG   = cfg_link_pkg::RESET_CFG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_en,
  input  logic                 cfg_data,
  input  logic                 cfg_sclk,
  output logic [CFG_WIDTH-1:0] cfg_out,
  output logic                 cfg_valid,
  output logic                 cfg_error,
  output logic                 busy
);
  import cfg_link_pkg::*;

  localparam int             CW       = $clog2(CFG_WIDTH + 2);
  localparam logic [CW-1:0]  CNT_FULL = CW'(CFG_WIDTH);
  localparam logic [CW-1:0]  CNT_OVF  = CW'(CFG_WIDTH + 1);

  logic en_s, sclk_s, data_s;
  logic en_prev_q, sclk_prev_q;
  logic en_fall, sclk_rise;

  state_e               state_q;
  logic [CFG_WIDTH-1:0] shreg_q;
  logic [CW-1:0]        cnt_q;
  logic [CFG_WIDTH-1:0] cfg_out_q;
  logic                 cfg_valid_q, cfg_error_q, busy_q;

  // Identical depth on all three keeps data aligned with its sclk edge.
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_en   (.clk(clk), .rst_n(rst_n), .d_i(cfg_en),   .q_o(en_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d_i(cfg_sclk), .q_o(sclk_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_data (.clk(clk), .rst_n(rst_n), .d_i(cfg_data), .q_o(data_s));

  assign en_fall   = en_prev_q & ~en_s;
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      cfg_out_q   <= RESET_CFG;
      cfg_valid_q <= 1'b0;
      cfg_error_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      en_prev_q   <= en_s;
      sclk_prev_q <= sclk_s;
      cfg_valid_q <= 1'b0;
      case (state_q)
        // Level test: en only reads high in IDLE after a rise, and this also
        // picks up a rise that landed during the COMMIT cycle.
        ST_IDLE: begin
          if (en_s) begin
            state_q <= ST_SHIFT;
            shreg_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            shreg_q <= {data_s, shreg_q[CFG_WIDTH-1:1]};
            if (cnt_q != CNT_OVF) cnt_q <= cnt_q + 1'b1;
          end
          if (en_fall) state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          if (cnt_q == CNT_FULL) begin
            cfg_out_q   <= shreg_q;
            cfg_valid_q <= 1'b1;
            cfg_error_q <= 1'b0;
          end else if (cnt_q != '0) begin
            cfg_error_q <= 1'b1;
          end
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_out   = cfg_out_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_error = cfg_error_q;
  assign busy      = busy_q;
endmodule
